seg7_scan_driver: RTL
=====================

// Module: seg7_scan_driver
// PURPOSE
//  Multiplexed 7-segment display driver; sits directly downstream of clock_divider3.
//  Consumes the divider's slow toggling clk_out as a scan-rate reference.
//  On each scan edge, steps to the next digit, inserting an anti-ghosting dead time.
//  Decodes each hex nibble (adder operands and sum) to active-low segment drives.
// PARAMETERS
//  DIGITS    4  number of multiplexed digits (>=2)
//  DEAD_CYC  8  clk_in cycles with all anodes off after each digit step (>=1)
// PORTS
//  clk_in       in   1         system clock; all logic on posedge clk_in
//  rst          in   1         asynchronous, active-high reset
//  scan_tick    in   1         toggling level from clock_divider3 clk_out; async to logic, synchronised here
//  data         in   4*DIGITS  hex nibbles; digit i = data[4i+3:4i]; digit 0 is rightmost
//  dp_in        in   DIGITS    decimal point request per digit, active-high
//  an           out  DIGITS    anode enables, active-low, one-hot or all-off
//  seg          out  7         segments {g,f,e,d,c,b,a}, active-low
//  dp           out  1         decimal point, active-low
//  frame_start  out  1         1-cycle pulse when digit 0 is selected and data is latched
// BEHAVIOUR
//  - Reset: an=all 1s, seg=7'h7F, dp=1, frame_start=0, idx=0, state=S_DEAD, dead_cnt=0,
//    shadow data and dp = 0. Until the first wrap to digit 0, the display shows zeros.
//  - Sync: scan_tick passes through 2 flops (s1,s2), then a history flop s3.
//  - step = s2^s3. Both edges of scan_tick count as steps, so refresh rate = 2x the divider toggle rate.
//  - step is high 2-3 clk_in cycles after a scan_tick transition.
//  - FSM states S_DEAD and S_ON. All outputs are registered.
//    S_DEAD: an=all 1s, seg=7F, dp=1. dead_cnt increments each cycle.
//      When dead_cnt==DEAD_CYC-1: go to S_ON, with an/seg/dp valid the next cycle.
//    S_ON: an[idx]=0 (all other bits 1). seg=decode(shadow[idx]). dp=~shadow_dp[idx].
//    A step in either state does the following:
//      idx <= (idx==DIGITS-1) ? 0 : idx+1   (wrap-around)
//      state <= S_DEAD, dead_cnt <= 0; an goes all-off on the next cycle.
//    A step during S_DEAD restarts the dead time at the new idx.
//  - Frame latch: a step that wraps idx to 0 copies data->shadow and dp_in->shadow_dp in the same edge.
//    frame_start=1 for exactly that one cycle.
//    data changes mid-frame are invisible until the next wrap (no tearing).
//  - Decode (hex, active-low gfedcba), fixed table:
//    0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
//  - Only one anode may be low in any cycle. An anode change is always separated by >= DEAD_CYC all-off cycles.
//  - Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous).
//    After release, scanning resumes from idx=0 in S_DEAD.
// CONFIGURATION
//  SEG7_BLANK_EN defined: leading-zero blanking, computed at frame latch.
//    Digit i (i>0) is blank if shadow[i]==0 and every digit above i is also 0.
//    For a blank digit: seg=7F in S_ON, anode still asserted, dp still follows shadow_dp.
//    Digit 0 is never blanked.
//  SEG7_BLANK_EN undefined: all digits are always decoded; no blank logic is synthesised.
// TESTING
//  1. Reset held, toggle scan_tick -> an=4'hF, seg=7F, dp=1, frame_start=0 throughout.
//  2. data=16'h3A7F, dp_in=0; 8 scan_tick toggles spaced 100 cycles apart.
//     -> frame_start once per 4 steps; digits show F=0E, 7=78, A=08, 3=30.
//     -> an sequence 1110, 1101, 1011, 0111, with 8 all-off cycles before each.
//  3. Change data from 16'h1111 to 16'h2222 while idx=2 -> digits 2 and 3 still show 79.
//     The value 24 appears only after the next frame_start.
//  4. Two scan_tick toggles 4 cycles apart -> second step restarts the dead time.
//     No anode goes low between the steps; idx advances by 2.
//  5. Assert rst while idx=3 in S_ON -> an=F, seg=7F on the same edge.
//     After release, the first lit anode is 1110.
//  6. With SEG7_BLANK_EN, data=16'h0050 -> digits 3,2 seg=7F with anodes active; digit 1=12, digit 0=40.
//     Without SEG7_BLANK_EN -> digits 3,2 show 40.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for seg7_scan_driver: scan reference and digit data in,
// multiplexed anode/segment drives and frame marker out.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic                  scan_tick;
    logic [4*DIGITS-1:0]   data;
    logic [DIGITS-1:0]     dp_in;
    logic [DIGITS-1:0]     an;
    logic [6:0]            seg;
    logic                  dp;
    logic                  frame_start;

    modport master (
        output scan_tick, data, dp_in,
        input  an, seg, dp, frame_start
    );

    modport slave (
        input  scan_tick, data, dp_in,
        output an, seg, dp, frame_start
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: steps digits on both edges of scan_tick with an
// all-off dead time. Define SEG7_BLANK_EN to enable leading-zero blanking.
module seg7_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int DEAD_CYC = 8
) (
    input  logic              clk_in,
    input  logic              rst,
    seg7_scan_driver_if.slave bus
);
    localparam int IW = $clog2(DIGITS);
    localparam int CW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

    typedef enum logic {S_DEAD, S_ON} state_t;

    logic              s1_reg, s2_reg, s3_reg;
    logic              step;
    logic              wrap;
    state_t            state_reg, state_next;
    logic [CW-1:0]     dead_reg, dead_next;
    logic [IW-1:0]     idx_reg, idx_next;
    logic [3:0]        data_nib [DIGITS];
    logic [3:0]        shadow_reg [DIGITS];
    logic [DIGITS-1:0] shadow_dp_reg;
    logic [DIGITS-1:0] an_reg, an_next;
    logic [6:0]        seg_reg, seg_next;
    logic              dp_reg, dp_next;
    logic              frame_start_reg;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;  default: decode = 7'h0E;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_nib
            assign data_nib[gi] = bus.data[4*gi +: 4];
        end
    endgenerate

    // s3 is only a history flop; comparing it with s2 turns either edge into a step
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
            s3_reg <= 1'b0;
        end else begin
            s1_reg <= bus.scan_tick;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    assign step = s2_reg ^ s3_reg;
    assign wrap = step && (idx_reg == IW'(DIGITS - 1));

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) shadow_reg[i] <= 4'h0;
            shadow_dp_reg <= '0;
        end else if (wrap) begin
            for (int i = 0; i < DIGITS; i++) shadow_reg[i] <= data_nib[i];
            shadow_dp_reg <= bus.dp_in;
        end
    end

`ifdef SEG7_BLANK_EN
    logic [DIGITS-1:0] blank_reg, blank_next;

    // A digit blanks only while every digit from the top down to it is zero
    always_comb begin
        logic run;
        blank_next = '0;
        run        = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            run           = run && (data_nib[i] == 4'h0);
            blank_next[i] = run;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst)       blank_reg <= '0;
        else if (wrap) blank_reg <= blank_next;
    end
`endif

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_reg <= S_DEAD;
            dead_reg  <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            dead_reg  <= dead_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        dead_next  = dead_reg;
        idx_next   = idx_reg;
        if (step) begin
            idx_next   = wrap ? '0 : idx_reg + IW'(1);
            state_next = S_DEAD;
            dead_next  = '0;
        end else if (state_reg == S_DEAD) begin
            if (dead_reg == CW'(DEAD_CYC - 1)) state_next = S_ON;
            else                               dead_next  = dead_reg + CW'(1);
        end
    end

    // Outputs are computed from the next state so the registered drives track state_reg
    always_comb begin
        an_next  = '1;
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        if (state_next == S_ON) begin
            an_next[idx_next] = 1'b0;
            seg_next          = decode(shadow_reg[idx_next]);
`ifdef SEG7_BLANK_EN
            if (blank_reg[idx_next]) seg_next = 7'h7F;
`endif
            dp_next           = ~shadow_dp_reg[idx_next];
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            an_reg          <= '1;
            seg_reg         <= 7'h7F;
            dp_reg          <= 1'b1;
            frame_start_reg <= 1'b0;
        end else begin
            an_reg          <= an_next;
            seg_reg         <= seg_next;
            dp_reg          <= dp_next;
            frame_start_reg <= wrap;
        end
    end

    assign bus.an          = an_reg;
    assign bus.seg         = seg_reg;
    assign bus.dp          = dp_reg;
    assign bus.frame_start = frame_start_reg;
endmodule
